// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - ratio request handshake and divided-clock outputs of clk_div_gen
interface clk_div_gen_if #(
    parameter int DIV_WIDTH = 8
);
    logic                 CLK_EN;
    logic [DIV_WIDTH-1:0] DIV_RATIO;
    logic                 RATIO_VLD;
    logic                 RATIO_ACK;
    logic                 DIV_CLK;
    logic                 DIV_TICK;

    modport master (
        output CLK_EN, DIV_RATIO, RATIO_VLD,
        input  RATIO_ACK, DIV_CLK, DIV_TICK
    );

    modport slave (
        input  CLK_EN, DIV_RATIO, RATIO_VLD,
        output RATIO_ACK, DIV_CLK, DIV_TICK
    );
endinterface

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - integer clock divider with boundary-aligned ratio update and bypass
module clk_div_gen #(
    parameter int DIV_WIDTH   = 8,
    parameter int RESET_RATIO = 2
) (
    input  logic          CLK,
    input  logic          RST,
    clk_div_gen_if.slave  bus
);
    localparam logic [DIV_WIDTH-1:0] RESET_RATIO_W = DIV_WIDTH'(RESET_RATIO);

    logic [DIV_WIDTH-1:0] act_ratio;
    logic [DIV_WIDTH-1:0] pend_ratio;
    logic [DIV_WIDTH-1:0] cnt;
    logic                 pend_v;
    logic                 byp_q;
    logic                 div_q;
    logic                 run_q;
    logic                 ratio_ack;
    logic                 div_tick;

    logic                 bypass_now;
    logic                 at_wrap;
    logic                 apply;
    logic [DIV_WIDTH-1:0] act_n;
    logic [DIV_WIDTH-1:0] cnt_n;
    logic [DIV_WIDTH:0]   half_n;

    // run_q marks that the current cycle belongs to a divide period, so the
    // first divide cycle after reset or bypass always starts a fresh period.
    always_comb begin
        bypass_now = !bus.CLK_EN || (act_ratio < DIV_WIDTH'(2));
        at_wrap    = run_q && (cnt == (act_ratio - DIV_WIDTH'(1)));
        apply      = pend_v && (bypass_now || at_wrap);
        act_n      = apply ? pend_ratio : act_ratio;
        cnt_n      = (!run_q || at_wrap) ? '0 : cnt + DIV_WIDTH'(1);
        half_n     = ({1'b0, act_n} + 1'b1) >> 1;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            act_ratio  <= RESET_RATIO_W;
            pend_ratio <= '0;
            cnt        <= '0;
            pend_v     <= 1'b0;
            byp_q      <= 1'b0;
            div_q      <= 1'b0;
            run_q      <= 1'b0;
            ratio_ack  <= 1'b0;
            div_tick   <= 1'b0;
        end else begin
            byp_q     <= bypass_now;
            ratio_ack <= bus.RATIO_VLD;

            // A capture in the apply cycle keeps pend_v set: the old value is
            // applied now, the new one waits for the next boundary.
            if (bus.RATIO_VLD) begin
                pend_ratio <= bus.DIV_RATIO;
                pend_v     <= 1'b1;
            end else if (apply) begin
                pend_v <= 1'b0;
            end
            if (apply) begin
                act_ratio <= pend_ratio;
            end

            if (bypass_now) begin
                cnt      <= '0;
                div_q    <= 1'b0;
                run_q    <= 1'b0;
                div_tick <= bus.CLK_EN;
            end else if (act_n < DIV_WIDTH'(2)) begin
                // Boundary into ratio 0/1: hold low one cycle before bypass engages.
                cnt      <= '0;
                div_q    <= 1'b0;
                run_q    <= 1'b0;
                div_tick <= 1'b0;
            end else begin
                cnt      <= cnt_n;
                div_q    <= ({1'b0, cnt_n} < half_n);
                run_q    <= 1'b1;
                div_tick <= (cnt_n == '0);
            end
        end
    end

    assign bus.DIV_CLK   = byp_q ? CLK : div_q;
    assign bus.DIV_TICK  = div_tick;
    assign bus.RATIO_ACK = ratio_ack;
endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - table-driven directed bench for clk_div_gen
module tb_clk_div_gen;
    typedef struct {
        logic       en;
        logic [7:0] ratio;
        logic       vld;
        logic       hi;
        logic       lo;
        logic       tick;
        logic       ack;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    clk_div_gen_if #(.DIV_WIDTH(8)) bus ();

    clk_div_gen #(.DIV_WIDTH(8), .RESET_RATIO(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int idx, input string what,
                       input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] %s got %b want %b", name, idx, what, got, want);
        end
    endtask

    task automatic add(input logic en, input logic [7:0] ratio, input logic vld,
                       input logic hi, input logic lo, input logic tick, input logic ack);
        vec_t v;
        v.en = en; v.ratio = ratio; v.vld = vld;
        v.hi = hi; v.lo = lo; v.tick = tick; v.ack = ack;
        vecs.push_back(v);
    endtask

    // One full output period at steady ratio n: high for ceil(n/2) cycles.
    task automatic add_period(input int n);
        for (int i = 0; i < n; i++) begin
            add(1'b1, 8'd0, 1'b0, (i < (n + 1) / 2), (i < (n + 1) / 2), (i == 0), 1'b0);
        end
    endtask

    // Inputs are driven away from the edge; DIV_CLK is sampled in both CLK phases.
    task automatic step(input vec_t v, input string name, input int idx);
        bus.CLK_EN    = v.en;
        bus.DIV_RATIO = v.ratio;
        bus.RATIO_VLD = v.vld;
        @(posedge CLK);
        #1;
        chk(name, idx, "div_clk_hi", bus.DIV_CLK, v.hi);
        chk(name, idx, "div_tick", bus.DIV_TICK, v.tick);
        chk(name, idx, "ratio_ack", bus.RATIO_ACK, v.ack);
        @(negedge CLK);
        #1;
        chk(name, idx, "div_clk_lo", bus.DIV_CLK, v.lo);
    endtask

    initial begin
        vec_t v;

        // ratio 2 after reset, then 5 requested at a boundary (applied one period later)
        add_period(2);
        add_period(2);
        add(1, 8'd5, 1, 1, 1, 1, 1);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add_period(5);
        // ratio 4 requested mid-period
        add(1, 8'd0, 0, 1, 1, 1, 0);
        add(1, 8'd4, 1, 1, 1, 0, 1);
        add(1, 8'd0, 0, 1, 1, 0, 0);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add_period(4);
        // 7 then 3 before the boundary: only 3 takes effect
        add(1, 8'd0, 0, 1, 1, 1, 0);
        add(1, 8'd7, 1, 1, 1, 0, 1);
        add(1, 8'd3, 1, 0, 0, 0, 1);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add_period(3);
        // 5, 4, 6 mid-period, then 4 at the boundary: 6 applied, 4 the period after
        add(1, 8'd5, 1, 1, 1, 1, 1);
        add(1, 8'd4, 1, 1, 1, 0, 1);
        add(1, 8'd6, 1, 0, 0, 0, 1);
        add(1, 8'd4, 1, 1, 1, 1, 1);
        add(1, 8'd0, 0, 1, 1, 0, 0);
        add(1, 8'd0, 0, 1, 1, 0, 0);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add_period(4);
        add_period(4);
        // CLK_EN drops mid-period; ratio 6 requested during bypass
        add(1, 8'd0, 0, 1, 1, 1, 0);
        add(1, 8'd0, 0, 1, 1, 0, 0);
        add(0, 8'd0, 0, 1, 0, 0, 0);
        add(0, 8'd0, 0, 1, 0, 0, 0);
        add(0, 8'd0, 0, 1, 0, 0, 0);
        add(0, 8'd6, 1, 1, 0, 0, 1);
        add(0, 8'd0, 0, 1, 0, 0, 0);
        add_period(6);
        add_period(6);
        // ratio 1: low gap cycle at the boundary, then bypass with TICK every cycle
        add(1, 8'd1, 1, 1, 1, 1, 1);
        add(1, 8'd0, 0, 1, 1, 0, 0);
        add(1, 8'd0, 0, 1, 1, 0, 0);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add(1, 8'd0, 0, 1, 0, 1, 0);
        add(1, 8'd0, 0, 1, 0, 1, 0);
        add(1, 8'd0, 0, 1, 0, 1, 0);
        // ratio 4 from bypass: applied at once, clean restart
        add(1, 8'd4, 1, 1, 0, 1, 1);
        add(1, 8'd0, 0, 1, 0, 1, 0);
        add_period(4);
        // maximum ratio 255
        add(1, 8'd255, 1, 1, 1, 1, 1);
        add(1, 8'd0, 0, 1, 1, 0, 0);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add(1, 8'd0, 0, 0, 0, 0, 0);
        add_period(255);
        add_period(255);

        // reset held with a request present: outputs low, no ACK
        RST = 1'b0;
        v = '{en: 1, ratio: 8'd9, vld: 1, hi: 0, lo: 0, tick: 0, ack: 0};
        step(v, "reset", 0);
        step(v, "reset", 1);
        RST = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i], "vec", i);
        end

        // reset mid-operation with a pending request: lost, ratio back to 2
        v = '{en: 1, ratio: 8'd9, vld: 1, hi: 1, lo: 1, tick: 1, ack: 1};
        step(v, "midrst", 0);
        RST = 1'b0;
        v = '{en: 1, ratio: 8'd3, vld: 1, hi: 0, lo: 0, tick: 0, ack: 0};
        step(v, "midrst", 1);
        RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = '{en: 1, ratio: 8'd0, vld: 0, hi: (i % 2 == 0), lo: (i % 2 == 0),
                  tick: (i % 2 == 0), ack: 0};
            step(v, "after_rst", i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
